// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: single-beat data-bus access with lane steering,
// load extraction/extension, pipeline stall and writeback/forwarding result.
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic        mem_we_i,
    input  logic        mem_re_i,
    input  logic [2:0]  mem_size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        reg_wen_i,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  rd_addr_o,
    output logic        reg_wen_o,
    output logic [31:0] rd_wdata_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t        state, state_next;
    logic [CW-1:0] tcnt;
    logic          timeout;

    logic          is_mem, illegal, misaligned;
    logic          accept, reject, alu_op;

    logic          load_q;
    logic [2:0]    size_q;
    logic [1:0]    lane_q;
    logic [4:0]    rd_q;
    logic          wen_q;

    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;

    always_comb begin
        is_mem     = mem_we_i | mem_re_i;
        illegal    = (mem_we_i & mem_re_i) | (mem_size_i == 3'b011) |
                     (mem_size_i[2:1] == 2'b11) | (mem_we_i & mem_size_i[2]);
        misaligned = ((mem_size_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)) ||
                     ((mem_size_i[1:0] == 2'b01) && addr_i[0]);
        accept     = (state == IDLE) && valid_i && is_mem && !illegal && !misaligned;
        reject     = (state == IDLE) && valid_i && is_mem && (illegal || misaligned);
        alu_op     = (state == IDLE) && valid_i && !is_mem;
    end

    // Timeout fires in the TIMEOUT_CYCLES-th cycle spent in REQ or WAIT.
    assign timeout = (TIMEOUT_CYCLES != 0) && (tcnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = REQ;
                    stall_o    = 1'b1;
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (bus_gnt_i)    state_next = load_q ? WAIT : RESP;
                else if (timeout) state_next = RESP;
            end
            WAIT: begin
                stall_o = 1'b1;
                if (bus_rvalid_i || timeout) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if ((state_next != state) && (state_next == REQ || state_next == WAIT)) begin
            tcnt <= '0;
        end else if ((state == REQ || state == WAIT) && (TIMEOUT_CYCLES != 0)) begin
            tcnt <= tcnt + CW'(1);
        end
    end

    always_comb begin
        byte_sel = bus_rdata_i[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (size_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = bus_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            wb_valid_o  <= 1'b0;
            rd_addr_o   <= '0;
            reg_wen_o   <= 1'b0;
            rd_wdata_o  <= '0;
            err_o       <= 1'b0;
            load_q      <= 1'b0;
            size_q      <= '0;
            lane_q      <= '0;
            rd_q        <= '0;
            wen_q       <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            reg_wen_o  <= 1'b0;
            err_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (alu_op) begin
                        wb_valid_o <= 1'b1;
                        rd_wdata_o <= addr_i;
                        rd_addr_o  <= rd_addr_i;
                        reg_wen_o  <= reg_wen_i;
                    end
                    if (reject) err_o <= 1'b1;
                    if (accept) begin
                        load_q     <= mem_re_i;
                        size_q     <= mem_size_i;
                        lane_q     <= addr_i[1:0];
                        rd_q       <= rd_addr_i;
                        wen_q      <= reg_wen_i;
                        bus_req_o  <= 1'b1;
                        bus_we_o   <= mem_we_i;
                        bus_addr_o <= {addr_i[31:2], 2'b00};
                        if (mem_we_i) begin
                            case (mem_size_i[1:0])
                                2'b00: begin
                                    bus_be_o    <= 4'b0001 << addr_i[1:0];
                                    bus_wdata_o <= {4{wdata_i[7:0]}};
                                end
                                2'b01: begin
                                    bus_be_o    <= addr_i[1] ? 4'b1100 : 4'b0011;
                                    bus_wdata_o <= {2{wdata_i[15:0]}};
                                end
                                default: begin
                                    bus_be_o    <= 4'b1111;
                                    bus_wdata_o <= wdata_i;
                                end
                            endcase
                        end else begin
                            bus_be_o    <= 4'b1111;
                            bus_wdata_o <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                    end else if (timeout) begin
                        bus_req_o <= 1'b0;
                        err_o     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus_rvalid_i) begin
                        wb_valid_o <= 1'b1;
                        rd_wdata_o <= load_data;
                        rd_addr_o  <= rd_q;
                        reg_wen_o  <= wen_q;
                    end else if (timeout) begin
                        err_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases plus randomized requests
// checked against an arithmetic model of the bus/writeback behaviour.
module tb_mem_lsu;

    logic        clk;
    logic        rst_n;
    logic        valid, mem_we, mem_re, reg_wen_in;
    logic [2:0]  mem_size;
    logic [31:0] addr, wdata;
    logic [4:0]  rd_addr_in;
    logic        gnt, rvalid;
    logic [31:0] rdata_bus;

    logic        stall, bus_req, bus_we, wb_valid, reg_wen, err;
    logic [31:0] bus_addr, bus_wdata, rd_wdata;
    logic [3:0]  bus_be;
    logic [4:0]  rd_addr;

    logic        stall_nt, bus_req_nt, bus_we_nt, wb_valid_nt, reg_wen_nt, err_nt;
    logic [31:0] bus_addr_nt, bus_wdata_nt, rd_wdata_nt;
    logic [3:0]  bus_be_nt;
    logic [4:0]  rd_addr_nt;

    int checks = 0;
    int errors = 0;

    mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .mem_we_i(mem_we), .mem_re_i(mem_re),
        .mem_size_i(mem_size), .addr_i(addr), .wdata_i(wdata), .rd_addr_i(rd_addr_in),
        .reg_wen_i(reg_wen_in), .stall_o(stall), .bus_req_o(bus_req), .bus_we_o(bus_we),
        .bus_addr_o(bus_addr), .bus_be_o(bus_be), .bus_wdata_o(bus_wdata),
        .bus_gnt_i(gnt), .bus_rvalid_i(rvalid), .bus_rdata_i(rdata_bus),
        .wb_valid_o(wb_valid), .rd_addr_o(rd_addr), .reg_wen_o(reg_wen),
        .rd_wdata_o(rd_wdata), .err_o(err)
    );

    mem_lsu #(.TIMEOUT_CYCLES(0)) dut_nt (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .mem_we_i(mem_we), .mem_re_i(mem_re),
        .mem_size_i(mem_size), .addr_i(addr), .wdata_i(wdata), .rd_addr_i(rd_addr_in),
        .reg_wen_i(reg_wen_in), .stall_o(stall_nt), .bus_req_o(bus_req_nt), .bus_we_o(bus_we_nt),
        .bus_addr_o(bus_addr_nt), .bus_be_o(bus_be_nt), .bus_wdata_o(bus_wdata_nt),
        .bus_gnt_i(gnt), .bus_rvalid_i(rvalid), .bus_rdata_i(rdata_bus),
        .wb_valid_o(wb_valid_nt), .rd_addr_o(rd_addr_nt), .reg_wen_o(reg_wen_nt),
        .rd_wdata_o(rd_wdata_nt), .err_o(err_nt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model ----
    function automatic int nbytes(input logic [2:0] size);
        case (size)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit op_ok(input logic we, input logic re, input logic [2:0] size,
                                 input logic [31:0] a);
        int n = nbytes(size);
        if (we && re) return 1'b0;
        if (n == 0) return 1'b0;
        if (we && size >= 3'd4) return 1'b0;
        return (a % n) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] size, input logic [31:0] a);
        int n = nbytes(size);
        int off = int'(a % 32'd4);
        logic [3:0] be = '0;
        for (int k = 0; k < 4; k++)
            if (k >= off && k < off + n) be[k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] size, input logic [31:0] w);
        int n = nbytes(size);
        if (n == 1) return (w % 32'd256) * 32'h0101_0101;
        if (n == 2) return (w % 32'd65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] size, input logic [31:0] a,
                                             input logic [31:0] r);
        longint n = longint'(nbytes(size));
        longint off = (n == 4) ? 0 : longint'(a % 32'd4);
        longint span = 64'd1 << (8 * n);
        longint v = (longint'(r) >> (8 * off)) % span;
        if (size < 3'd4 && n < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // One complete request from presentation in IDLE to return to IDLE.
    task automatic mem_op(input logic we, input logic re, input logic [2:0] size,
                          input logic [31:0] a, input logic [31:0] w, input logic [4:0] rd,
                          input logic wen, input int gd, input int rvd, input logic [31:0] r);
        bit mem = we || re;
        bit ok = op_ok(we, re, size, a);
        bit load = re && !we;
        valid = 1'b1; mem_we = we; mem_re = re; mem_size = size;
        addr = a; wdata = w; rd_addr_in = rd; reg_wen_in = wen;
        #1;
        chk("accept_stall", stall, mem && ok);
        step();
        if (!mem) begin
            valid = 1'b0;
            chk("alu_wb_valid", wb_valid, 1);
            chk("alu_rd_wdata", rd_wdata, a);
            chk("alu_rd_addr", rd_addr, rd);
            chk("alu_reg_wen", reg_wen, wen);
            chk("alu_err", err, 0);
            return;
        end
        if (!ok) begin
            valid = 1'b0;
            #1;
            chk("bad_err", err, 1);
            chk("bad_wb_valid", wb_valid, 0);
            chk("bad_bus_req", bus_req, 0);
            chk("bad_stall", stall, 0);
            step();
            chk("bad_err_pulse", err, 0);
            chk("bad_bus_req2", bus_req, 0);
            return;
        end
        for (int i = 0; i <= gd; i++) begin
            if (i == gd) begin
                gnt = 1'b1;
                if (load) begin rvalid = 1'b1; rdata_bus = ~r; end
            end
            chk("req_bus_req", bus_req, 1);
            chk("req_bus_we", bus_we, we);
            chk("req_bus_addr", bus_addr, a & 32'hFFFF_FFFC);
            chk("req_bus_be", bus_be, load ? 4'hF : exp_be(size, a));
            if (!load) chk("req_bus_wdata", bus_wdata, exp_wdata(size, w));
            chk("req_stall", stall, 1);
            step();
        end
        gnt = 1'b0; rvalid = 1'b0;
        chk("gnt_drop_req", bus_req, 0);
        if (!load) begin
            chk("st_resp_stall", stall, 0);
            chk("st_resp_wb_valid", wb_valid, 0);
            chk("st_resp_reg_wen", reg_wen, 0);
            chk("st_resp_err", err, 0);
            step();
            valid = 1'b0;
            #1;
            chk("st_no_reaccept", bus_req, 0);
            chk("st_idle_stall", stall, 0);
            return;
        end
        for (int j = 0; j <= rvd; j++) begin
            if (j == rvd) begin rvalid = 1'b1; rdata_bus = r; end
            chk("wait_stall", stall, 1);
            chk("wait_wb_valid", wb_valid, 0);
            step();
        end
        rvalid = 1'b0; rdata_bus = $urandom;
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_rd_wdata", rd_wdata, exp_load(size, a, r));
        chk("ld_rd_addr", rd_addr, rd);
        chk("ld_reg_wen", reg_wen, wen);
        chk("ld_resp_stall", stall, 0);
        chk("ld_err", err, 0);
        step();
        valid = 1'b0;
        #1;
        chk("ld_wb_pulse", wb_valid, 0);
        chk("ld_no_reaccept", bus_req, 0);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; mem_we = 1'b0; mem_re = 1'b0; mem_size = '0;
        addr = '0; wdata = '0; rd_addr_in = '0; reg_wen_in = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata_bus = '0;
        step(); step();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_rd_wdata", rd_wdata, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);
        rst_n = 1'b1;
        step();

        // directed cases
        mem_op(1, 0, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 5'd1, 1, 2, 0, 0);
        mem_op(1, 0, 3'b000, 32'h0000_0203, 32'h0000_0055, 5'd2, 1, 0, 0, 0);
        mem_op(1, 0, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd3, 1, 1, 0, 0);
        mem_op(0, 1, 3'b000, 32'h0000_0101, 32'h0, 5'd4, 1, 0, 0, 32'h0000_8000);
        mem_op(0, 1, 3'b100, 32'h0000_0101, 32'h0, 5'd5, 1, 1, 1, 32'h0000_8000);
        mem_op(0, 1, 3'b001, 32'h0000_0102, 32'h0, 5'd6, 1, 0, 1, 32'h8001_0000);
        mem_op(0, 1, 3'b010, 32'h0000_0200, 32'h0, 5'd7, 1, 1, 2, 32'hCAFE_F00D);
        mem_op(0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd9, 1, 0, 0, 0);
        mem_op(0, 1, 3'b010, 32'h0000_0102, 32'h0, 5'd8, 1, 0, 0, 0);
        mem_op(0, 1, 3'b011, 32'h0000_0100, 32'h0, 5'd8, 1, 0, 0, 0);
        mem_op(1, 1, 3'b010, 32'h0000_0100, 32'h0, 5'd8, 1, 0, 0, 0);
        mem_op(1, 0, 3'b100, 32'h0000_0100, 32'h0, 5'd8, 1, 0, 0, 0);

        // randomized requests
        for (int t = 0; t < 80; t++) begin
            int kind = $urandom_range(0, 9);
            logic [2:0] sz;
            logic we_r, re_r;
            if ($urandom_range(0, 3) == 0) sz = 3'($urandom);
            else case ($urandom_range(0, 4))
                0: sz = 3'b000; 1: sz = 3'b001; 2: sz = 3'b010; 3: sz = 3'b100; default: sz = 3'b101;
            endcase
            we_r = (kind >= 6); re_r = (kind >= 2 && kind <= 5) || kind == 9;
            mem_op(we_r, re_r, sz, $urandom, $urandom, 5'($urandom), 1'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
            if ($urandom_range(0, 2) == 0) step();
        end

        // timeout: dut gives up after 4 REQ cycles, dut_nt keeps waiting
        valid = 1'b1; mem_we = 1'b1; mem_re = 1'b0; mem_size = 3'b010;
        addr = 32'h0000_0040; wdata = 32'h0BAD_F00D;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("to_bus_req", bus_req, 1);
            chk("to_stall", stall, 1);
            step();
        end
        valid = 1'b0;
        #1;
        chk("to_req_drop", bus_req, 0);
        chk("to_err", err, 1);
        chk("to_wb_valid", wb_valid, 0);
        chk("to_stall_release", stall, 0);
        repeat (16) step();
        chk("nt_still_req", bus_req_nt, 1);
        chk("nt_still_stall", stall_nt, 1);
        chk("nt_no_err", err_nt, 0);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("nt_gnt_drop", bus_req_nt, 0);
        chk("nt_resp_stall", stall_nt, 0);
        chk("to_idle_ignores_gnt", bus_req, 0);
        step();

        // reset while waiting for read data, then a late rvalid
        valid = 1'b1; mem_we = 1'b0; mem_re = 1'b1; mem_size = 3'b010; addr = 32'h0000_0300;
        rd_addr_in = 5'd12; reg_wen_in = 1'b1;
        step();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        step();
        chk("rw_in_wait", stall, 1);
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rw_bus_req", bus_req, 0);
        chk("rw_bus_we", bus_we, 0);
        chk("rw_bus_addr", bus_addr, 0);
        chk("rw_bus_be", bus_be, 0);
        chk("rw_rd_addr", rd_addr, 0);
        chk("rw_stall", stall, 0);
        step();
        rst_n = 1'b1;
        step();
        rvalid = 1'b1; rdata_bus = 32'h1234_5678;
        step();
        rvalid = 1'b0;
        chk("late_rv_wb_valid", wb_valid, 0);
        chk("late_rv_rd_wdata", rd_wdata, 0);
        chk("late_rv_stall", stall, 0);
        chk("late_rv_bus_req", bus_req, 0);
        mem_op(0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd13, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
